hazard_fwd_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage pipeline; successor to the 2-source forwarding unit.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/fwd_src_sel.sv | 36 +++
 rtl/hazard_fwd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: EX operand-forward selects and hazard-controller states.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MEM_WAIT,
        HZ_TMO
    } hz_state_t;

endpackage

// File: rtl/fwd_src_sel.sv
// Forwarding decision for a single source operand: EX mux select and WB->ID bypass.
module fwd_src_sel
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic              ex_mem_memread,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    output fwd_sel_t          fwd_ex,
    output logic              fwd_id
);

    logic mem_src_ok;
    logic wb_src_ok;

    // A load in MEM has no data yet, so it is never a forwarding source.
    assign mem_src_ok = ex_mem_regwrite && !ex_mem_memread && (ex_mem_rd != '0);
    assign wb_src_ok  = mem_wb_regwrite && (mem_wb_rd != '0);

    always_comb begin
        fwd_ex = FWD_REG;
        if (mem_src_ok && (ex_mem_rd == ex_rs)) begin
            fwd_ex = FWD_MEM;
        end else if (wb_src_ok && (mem_wb_rd == ex_rs)) begin
            fwd_ex = FWD_WB;
        end
    end

    assign fwd_id = wb_src_ok && (mem_wb_rd == id_rs);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: per-source forwarding, load-use bubbles and a
// data-memory wait FSM with timeout, sticky error flag and stall counter.
module hazard_fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
    input  logic [REG_AW-1:0]         id_ex_rd,
    input  logic                      id_ex_memread,
    input  logic [REG_AW-1:0]         ex_mem_rd,
    input  logic                      ex_mem_regwrite,
    input  logic                      ex_mem_memread,
    input  logic [REG_AW-1:0]         mem_wb_rd,
    input  logic                      mem_wb_regwrite,
    input  logic                      dmem_valid,
    input  logic                      err_clr,
    output logic [NUM_SRC*2-1:0]      fwd_ex,
    output logic [NUM_SRC-1:0]        fwd_id,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_ex,
    output logic                      stall_ex,
    output logic                      stall_mem,
    output logic                      flush_wb,
    output logic                      err_timeout,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int unsigned       WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    hz_state_t          state;
    logic [WAIT_W-1:0]  wait_cnt;
    fwd_sel_t           src_fwd_ex [NUM_SRC];
    logic [NUM_SRC-1:0] src_fwd_id;
    logic               load_use;
    logic               mem_busy;
    logic               mem_stall;
    logic               tmo_flush;
    logic               bubble;
    logic               any_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_sel #(
            .REG_AW(REG_AW)
        ) u_sel (
            .ex_rs           (id_ex_rs[g*REG_AW +: REG_AW]),
            .id_rs           (id_rs[g*REG_AW +: REG_AW]),
            .ex_mem_rd       (ex_mem_rd),
            .ex_mem_regwrite (ex_mem_regwrite),
            .ex_mem_memread  (ex_mem_memread),
            .mem_wb_rd       (mem_wb_rd),
            .mem_wb_regwrite (mem_wb_regwrite),
            .fwd_ex          (src_fwd_ex[g]),
            .fwd_id          (src_fwd_id[g])
        );

        assign fwd_ex[2*g +: 2] = rst_n ? src_fwd_ex[g] : FWD_REG;
        assign fwd_id[g]        = rst_n && src_fwd_id[g];
    end

    always_comb begin
        load_use = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == id_ex_rd)) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && id_ex_memread && (id_ex_rd != '0);
    end

    assign mem_busy = ex_mem_memread && !dmem_valid;

    always_comb begin
        mem_stall = 1'b0;
        tmo_flush = 1'b0;
        unique case (state)
            HZ_RUN:      mem_stall = mem_busy;
            HZ_MEM_WAIT: mem_stall = !dmem_valid && (wait_cnt != WAIT_LAST);
            HZ_TMO:      tmo_flush = 1'b1;
            default:     mem_stall = 1'b0;
        endcase
    end

    // A memory stall freezes the whole pipe, so the load-use hazard is simply
    // re-evaluated once the pipe moves again; any advancing cycle takes the bubble.
    assign bubble    = load_use && !mem_stall;
    assign any_stall = mem_stall || bubble;

    assign stall_if  = rst_n && any_stall;
    assign stall_id  = rst_n && any_stall;
    assign flush_ex  = rst_n && bubble;
    assign stall_ex  = rst_n && mem_stall;
    assign stall_mem = rst_n && mem_stall;
    assign flush_wb  = rst_n && (mem_stall || tmo_flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HZ_RUN;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state)
                HZ_RUN: begin
                    if (mem_busy) begin
                        state    <= HZ_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                HZ_MEM_WAIT: begin
                    if (dmem_valid) begin
                        state    <= HZ_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= HZ_TMO;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HZ_TMO: begin
                    state <= HZ_RUN;
                end
                default: begin
                    state    <= HZ_RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (state == HZ_TMO) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            if (any_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    a_bubble_not_frozen: assert property (@(posedge clk) disable iff (!rst_n)
        !(flush_ex && stall_ex));

    a_tmo_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        (state == HZ_TMO) |=> (state == HZ_RUN));

    a_mem_stall_flushes_wb: assert property (@(posedge clk) disable iff (!rst_n)
        stall_mem |-> (flush_wb && stall_if && stall_id && stall_ex));

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: vector table, directed multi-cycle sequences, random vs model.
module tb_hazard_fwd_ctrl;

    localparam int unsigned RAW  = 5;
    localparam int unsigned NS   = 2;
    localparam int unsigned TMO  = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    typedef struct packed {
        logic [9:0] id_rs;
        logic [1:0] used;
        logic [9:0] ex_rs;
        logic [4:0] id_ex_rd;
        logic       id_ex_memread;
        logic [4:0] ex_mem_rd;
        logic       ex_mem_regwrite;
        logic       ex_mem_memread;
        logic [4:0] mem_wb_rd;
        logic       mem_wb_regwrite;
        logic       dmem_valid;
        logic       err_clr;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic [3:0] fwd_ex;
        logic [1:0] fwd_id;
        logic       bubble;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NS*RAW-1:0]     id_rs = '0;
    logic [NS-1:0]         id_rs_used = '0;
    logic [NS*RAW-1:0]     id_ex_rs = '0;
    logic [RAW-1:0]        id_ex_rd = '0;
    logic                  id_ex_memread = 1'b0;
    logic [RAW-1:0]        ex_mem_rd = '0;
    logic                  ex_mem_regwrite = 1'b0;
    logic                  ex_mem_memread = 1'b0;
    logic [RAW-1:0]        mem_wb_rd = '0;
    logic                  mem_wb_regwrite = 1'b0;
    logic                  dmem_valid = 1'b0;
    logic                  err_clr = 1'b0;
    logic [NS*2-1:0]       fwd_ex;
    logic [NS-1:0]         fwd_id;
    logic                  stall_if, stall_id, flush_ex, stall_ex, stall_mem, flush_wb;
    logic                  err_timeout;
    logic [CW-1:0]         stall_cnt;

    hazard_fwd_ctrl #(
        .REG_AW  (RAW),
        .NUM_SRC (NS),
        .TIMEOUT (TMO),
        .CNT_W   (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rs_used      (id_rs_used),
        .id_ex_rs        (id_ex_rs),
        .id_ex_rd        (id_ex_rd),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_memread  (ex_mem_memread),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .dmem_valid      (dmem_valid),
        .err_clr         (err_clr),
        .fwd_ex          (fwd_ex),
        .fwd_id          (fwd_id),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_ex        (flush_ex),
        .stall_ex        (stall_ex),
        .stall_mem       (stall_mem),
        .flush_wb        (flush_wb),
        .err_timeout     (err_timeout),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: m_w = cycles a load has waited so far (0 = not waiting).
    int   m_w, m_cnt;
    bit   m_tmo, m_err, m_stall;
    in_t  cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_fwd_ex(input in_t x);
        logic [3:0] r;
        logic [4:0] rs;
        r = '0;
        for (int s = 0; s < 2; s++) begin
            rs = x.ex_rs[s*5 +: 5];
            if (x.ex_mem_regwrite && !x.ex_mem_memread && x.ex_mem_rd != 0 && x.ex_mem_rd == rs)
                r[2*s +: 2] = 2'b10;
            else if (x.mem_wb_regwrite && x.mem_wb_rd != 0 && x.mem_wb_rd == rs)
                r[2*s +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic [1:0] ref_fwd_id(input in_t x);
        logic [1:0] r;
        for (int s = 0; s < 2; s++)
            r[s] = x.mem_wb_regwrite && x.mem_wb_rd != 0 && x.mem_wb_rd == x.id_rs[s*5 +: 5];
        return r;
    endfunction

    function automatic bit ref_load_use(input in_t x);
        bit hit;
        hit = 0;
        for (int s = 0; s < 2; s++)
            if (x.used[s] && x.id_rs[s*5 +: 5] == x.id_ex_rd) hit = 1;
        return hit && x.id_ex_memread && x.id_ex_rd != 0;
    endfunction

    function automatic vec_t mk(input logic [4:0] r1, input logic [4:0] r0, input logic [1:0] used,
                                input logic [4:0] e1, input logic [4:0] e0,
                                input logic [4:0] xrd, input logic xmr,
                                input logic [4:0] mrd, input logic mrw, input logic mmr,
                                input logic [4:0] wrd, input logic wrw,
                                input logic [3:0] efx, input logic [1:0] efi, input logic eb);
        vec_t v;
        v = '0;
        v.i.id_rs = {r1, r0};
        v.i.used = used;
        v.i.ex_rs = {e1, e0};
        v.i.id_ex_rd = xrd;
        v.i.id_ex_memread = xmr;
        v.i.ex_mem_rd = mrd;
        v.i.ex_mem_regwrite = mrw;
        v.i.ex_mem_memread = mmr;
        v.i.mem_wb_rd = wrd;
        v.i.mem_wb_regwrite = wrw;
        v.i.dmem_valid = 1'b1;
        v.fwd_ex = efx;
        v.fwd_id = efi;
        v.bubble = eb;
        return v;
    endfunction

    task automatic drive(input in_t x);
        id_rs = x.id_rs;
        id_rs_used = x.used;
        id_ex_rs = x.ex_rs;
        id_ex_rd = x.id_ex_rd;
        id_ex_memread = x.id_ex_memread;
        ex_mem_rd = x.ex_mem_rd;
        ex_mem_regwrite = x.ex_mem_regwrite;
        ex_mem_memread = x.ex_mem_memread;
        mem_wb_rd = x.mem_wb_rd;
        mem_wb_regwrite = x.mem_wb_regwrite;
        dmem_valid = x.dmem_valid;
        err_clr = x.err_clr;
    endtask

    task automatic apply(input in_t x);
        bit busy, ms, bub;
        cur = x;
        drive(x);
        #1;
        busy = x.ex_mem_memread && !x.dmem_valid;
        if (m_tmo)         ms = 0;
        else if (m_w == 0) ms = busy;
        else               ms = !x.dmem_valid && (m_w != TMO - 1);
        bub = ref_load_use(x) && !ms;
        m_stall = ms || bub;
        chk("fwd_ex",      32'(fwd_ex),      32'(ref_fwd_ex(x)));
        chk("fwd_id",      32'(fwd_id),      32'(ref_fwd_id(x)));
        chk("stall_if",    32'(stall_if),    32'(m_stall));
        chk("stall_id",    32'(stall_id),    32'(m_stall));
        chk("flush_ex",    32'(flush_ex),    32'(bub));
        chk("stall_ex",    32'(stall_ex),    32'(ms));
        chk("stall_mem",   32'(stall_mem),   32'(ms));
        chk("flush_wb",    32'(flush_wb),    32'(ms || m_tmo));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        chk("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
    endtask

    task automatic tick();
        bit busy;
        @(posedge clk);
        busy = cur.ex_mem_memread && !cur.dmem_valid;
        if (m_stall && m_cnt < CMAX) m_cnt++;
        if (m_tmo) m_err = 1;
        else if (cur.err_clr) m_err = 0;
        if (m_tmo) begin
            m_tmo = 0;
            m_w = 0;
        end else if (m_w == 0) begin
            m_w = busy ? 1 : 0;
        end else if (cur.dmem_valid) begin
            m_w = 0;
        end else if (m_w == TMO - 1) begin
            m_tmo = 1;
            m_w = 0;
        end else begin
            m_w++;
        end
        #1;
    endtask

    task automatic do_reset();
        in_t idle;
        idle = '0;
        rst_n = 1'b0;
        drive(idle);
        cur = idle;
        m_w = 0; m_cnt = 0; m_tmo = 0; m_err = 0; m_stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl [9];
    in_t  x, idle, ld, lu;

    initial begin
        idle = '0;
        tbl[0] = mk(5'd0, 5'd0, 2'b00, 5'd3, 5'd5, 5'd0, 0, 5'd5, 1, 0, 5'd5, 1, 4'b0010, 2'b00, 0);
        tbl[1] = mk(5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 1, 4'b0000, 2'b00, 0);
        tbl[2] = mk(5'd9, 5'd3, 2'b00, 5'd4, 5'd3, 5'd0, 0, 5'd4, 1, 0, 5'd3, 1, 4'b1001, 2'b01, 0);
        tbl[3] = mk(5'd6, 5'd2, 2'b00, 5'd6, 5'd6, 5'd0, 0, 5'd6, 1, 1, 5'd6, 1, 4'b0101, 2'b10, 0);
        tbl[4] = mk(5'd8, 5'd8, 2'b00, 5'd8, 5'd8, 5'd0, 0, 5'd8, 0, 0, 5'd8, 0, 4'b0000, 2'b00, 0);
        tbl[5] = mk(5'd7, 5'd1, 2'b10, 5'd0, 5'd0, 5'd7, 1, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 1);
        tbl[6] = mk(5'd7, 5'd1, 2'b01, 5'd0, 5'd0, 5'd7, 1, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 0);
        tbl[7] = mk(5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 0);
        tbl[8] = mk(5'd3, 5'd12, 2'b01, 5'd0, 5'd0, 5'd12, 1, 5'd0, 0, 0, 5'd0, 0, 4'b0000, 2'b00, 1);

        // Reset state
        rst_n = 1'b0;
        drive(idle);
        #2;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        do_reset();

        // Vector table (state stays RUN)
        for (int k = 0; k < 9; k++) begin
            apply(tbl[k].i);
            chk("tbl_fwd_ex", 32'(fwd_ex), 32'(tbl[k].fwd_ex));
            chk("tbl_fwd_id", 32'(fwd_id), 32'(tbl[k].fwd_id));
            chk("tbl_stall_id", 32'(stall_id), 32'(tbl[k].bubble));
            chk("tbl_flush_ex", 32'(flush_ex), 32'(tbl[k].bubble));
            tick();
        end

        // Load returns after 3 wait cycles
        do_reset();
        ld = '0;
        ld.ex_mem_memread = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(ld);
            chk("wait_stall_mem", 32'(stall_mem), 32'd1);
            tick();
        end
        x = ld;
        x.dmem_valid = 1'b1;
        apply(x);
        chk("wait_release", 32'(stall_if), 32'd0);
        tick();
        apply(idle);
        chk("wait_stall_cnt", 32'(stall_cnt), 32'd3);
        tick();

        // Timeout; err_clr during TMO must lose to the set
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply(ld);
            chk("tmo_stall", 32'(stall_if), 32'd1);
            tick();
        end
        apply(ld);
        chk("tmo_last_nostall", 32'(stall_if), 32'd0);
        chk("tmo_last_nowb", 32'(flush_wb), 32'd0);
        tick();
        x = ld;
        x.err_clr = 1'b1;
        apply(x);
        chk("tmo_flush_wb", 32'(flush_wb), 32'd1);
        chk("tmo_nostall", 32'(stall_mem), 32'd0);
        tick();
        apply(idle);
        chk("tmo_err_set", 32'(err_timeout), 32'd1);
        chk("tmo_stall_cnt", 32'(stall_cnt), 32'd3);
        tick();
        apply(idle);
        chk("tmo_err_sticky", 32'(err_timeout), 32'd1);
        tick();
        x = idle;
        x.err_clr = 1'b1;
        apply(x);
        tick();
        apply(idle);
        chk("tmo_err_clr", 32'(err_timeout), 32'd0);
        tick();

        // Async reset in MEM_WAIT
        do_reset();
        x = ld;
        x.mem_wb_rd = 5'd5;
        x.mem_wb_regwrite = 1'b1;
        x.ex_rs = {5'd0, 5'd5};
        x.id_rs = {5'd5, 5'd0};
        for (int k = 0; k < 2; k++) begin
            apply(x);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("arst_stall_if", 32'(stall_if), 32'd0);
        chk("arst_stall_mem", 32'(stall_mem), 32'd0);
        chk("arst_flush_wb", 32'(flush_wb), 32'd0);
        chk("arst_fwd_ex", 32'(fwd_ex), 32'd0);
        chk("arst_fwd_id", 32'(fwd_id), 32'd0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_err", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_w = 0; m_cnt = 0; m_tmo = 0; m_err = 0;
        apply(idle);
        chk("arst_rel_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_rel_stall", 32'(stall_if), 32'd0);
        tick();
        apply(ld);
        tick();
        apply(idle);
        tick();

        // Stall counter saturation
        do_reset();
        lu = '0;
        lu.id_ex_memread = 1'b1;
        lu.id_ex_rd = 5'd9;
        lu.id_rs = {5'd9, 5'd9};
        lu.used = 2'b11;
        for (int k = 0; k < 20; k++) begin
            apply(lu);
            tick();
        end
        apply(idle);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));
        tick();

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            x = '0;
            for (int s = 0; s < 2; s++) begin
                x.id_rs[s*5 +: 5] = 5'($urandom_range(0, 3));
                x.ex_rs[s*5 +: 5] = 5'($urandom_range(0, 3));
            end
            x.used = 2'($urandom_range(0, 3));
            x.id_ex_rd = 5'($urandom_range(0, 3));
            x.id_ex_memread = 1'($urandom_range(0, 1));
            x.ex_mem_rd = 5'($urandom_range(0, 3));
            x.ex_mem_regwrite = 1'($urandom_range(0, 1));
            x.ex_mem_memread = ($urandom_range(0, 2) == 0);
            x.mem_wb_rd = 5'($urandom_range(0, 3));
            x.mem_wb_regwrite = 1'($urandom_range(0, 1));
            x.dmem_valid = ($urandom_range(0, 3) == 0);
            x.err_clr = ($urandom_range(0, 7) == 0);
            apply(x);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
